// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and the load/store unit (LSU). One transaction in flight at a time.
// LSU has fixed priority, and a starvation counter lets a waiting IF win
// after STARVE_MAX consecutive lost arbitrations.
// Optional build macro ARB_PERF_EN adds grant and IF-stall counters.
// Handshake: a request transfers on a cycle where valid and ready are both
// high. Requesters keep valid and payload stable until ready. Dropping valid
// before ready withdraws the request. mem_req_valid is held with stable
// payload until mem_req_ready.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_we,
    input  logic [63:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    output logic [63:0] lsu_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data,
    output logic        busy,
`ifdef ARB_PERF_EN
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_lsu_grants,
    output logic [31:0] perf_if_stall,
`endif
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

    state_t     state;
    logic       owner_lsu;
    logic [3:0] starve_cnt;
    logic       starve_hit;
    logic       if_wins;
    logic       lsu_wins;
    logic       rsp_fire;

    // Arbitration happens only in IDLE. Readies are held low while rst is low,
    // so nothing is granted while the block is in reset.
    always_comb begin
        starve_hit = (starve_cnt == STARVE_LIM);
        if_wins    = rst && (state == IDLE) && if_req_valid &&
                     (!lsu_req_valid || starve_hit);
        lsu_wins   = rst && (state == IDLE) && lsu_req_valid &&
                     !(if_req_valid && starve_hit);
        rsp_fire   = (state == RSP) && mem_rsp_valid;
    end

    assign if_req_ready  = if_wins;
    assign lsu_req_ready = lsu_wins;

    // The response goes to whoever owns the transaction. The IF word is
    // selected by bit 2 of the captured address.
    assign if_rsp_valid  = rsp_fire && !owner_lsu;
    assign lsu_rsp_valid = rsp_fire && owner_lsu;
    assign if_rsp_data   = mem_addr[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
    assign lsu_rsp_data  = mem_rsp_data;

    assign busy           = (state != IDLE);
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    // Main FSM: capture the winner's request, present it to memory, wait for the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            owner_lsu     <= 1'b0;
            starve_cnt    <= 4'd0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 64'd0;
            mem_wdata     <= 64'd0;
            mem_wmask     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_wins) begin
                        owner_lsu     <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_we        <= lsu_we;
                        mem_addr      <= lsu_addr;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wmask;
                        state         <= REQ;
                        if (if_req_valid && !starve_hit) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (if_wins) begin
                        owner_lsu     <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= if_addr;
                        mem_wdata     <= 64'd0;
                        mem_wmask     <= 8'd0;
                        state         <= REQ;
                        starve_cnt    <= 4'd0;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_EN
    // Free-running grant and IF-stall counters. They wrap at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_grants  <= 32'd0;
            perf_lsu_grants <= 32'd0;
            perf_if_stall   <= 32'd0;
        end else begin
            if (if_wins) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (lsu_wins) begin
                perf_lsu_grants <= perf_lsu_grants + 32'd1;
            end
            if (if_req_valid && !if_req_ready) begin
                perf_if_stall <= perf_if_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter. Expected values
// are hand-computed. The grant order of the starvation run is held in an
// expected queue. Build with ARB_PERF_EN to also check the perf counters.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_we;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [63:0] lsu_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        busy;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_starve_cnt;
`ifdef ARB_PERF_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_lsu_grants;
    logic [31:0] perf_if_stall;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [0:0] exp_q[$];

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_rsp_valid   (if_rsp_valid),
        .if_rsp_data    (if_rsp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_we         (lsu_we),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_rsp_valid  (lsu_rsp_valid),
        .lsu_rsp_data   (lsu_rsp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .busy           (busy),
`ifdef ARB_PERF_EN
        .perf_if_grants (perf_if_grants),
        .perf_lsu_grants(perf_lsu_grants),
        .perf_if_stall  (perf_if_stall),
`endif
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check.
    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive point: just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point: falling edge.
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req_valid  = 1'b0;
        if_addr       = 64'd0;
        lsu_req_valid = 1'b0;
        lsu_we        = 1'b0;
        lsu_addr      = 64'd0;
        lsu_wdata     = 64'd0;
        lsu_wmask     = 8'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 64'd0;
    endtask

    initial begin
        logic [0:0] exp_g;
        int grants;
        int stall;
        logic [3:0] exp_cnt;
        logic if_prev;

        // ---------------- reset with both valids high ----------------
        idle_inputs();
        rst = 1'b0;
        if_req_valid  = 1'b1;
        lsu_req_valid = 1'b1;
        repeat (2) tick();
        settle();
        check_vec("rst_if_ready",  64'(if_req_ready), 64'd0);
        check_vec("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
        check_vec("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check_vec("rst_rsp_valid", 64'({if_rsp_valid, lsu_rsp_valid}), 64'd0);
        check_vec("rst_busy",      64'(busy), 64'd0);
        check_vec("rst_mem_addr",  mem_addr, 64'd0);
        check_vec("rst_state",     64'(dbg_state), 64'd0);
        tick();
        rst = 1'b1;
        settle();
        check_vec("rel_lsu_ready", 64'(lsu_req_ready), 64'd1);
        check_vec("rel_if_ready",  64'(if_req_ready), 64'd0);
        // Withdraw both requests before the edge so nothing is accepted.
        if_req_valid  = 1'b0;
        lsu_req_valid = 1'b0;
        tick();

        // ---------------- IF fetch, zero-wait memory ----------------
        if_req_valid  = 1'b1;
        if_addr       = 64'h0000_0000_8000_0004;
        mem_req_ready = 1'b1;
        settle();
        check_vec("if_ready", 64'(if_req_ready), 64'd1);
        tick();
        if_req_valid = 1'b0;
        settle();
        check_vec("if_mem_valid", 64'(mem_req_valid), 64'd1);
        check_vec("if_mem_addr",  mem_addr, 64'h0000_0000_8000_0004);
        check_vec("if_mem_we",    64'(mem_we), 64'd0);
        check_vec("if_mem_wmask", 64'(mem_wmask), 64'd0);
        check_vec("if_busy",      64'(busy), 64'd1);
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h1122_3344_5566_7788;
        settle();
        check_vec("if_rsp_valid", 64'(if_rsp_valid), 64'd1);
        check_vec("if_rsp_data",  64'(if_rsp_data), 64'h1122_3344);
        check_vec("if_lsu_quiet", 64'(lsu_rsp_valid), 64'd0);
        check_vec("if_mem_drop",  64'(mem_req_valid), 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        check_vec("if_done_busy", 64'(busy), 64'd0);
        check_vec("if_rsp_once",  64'(if_rsp_valid), 64'd0);

        // ---------------- LSU store with 3 wait states ----------------
        tick();
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b1;
        lsu_addr      = 64'h0000_0000_8000_1000;
        lsu_wdata     = 64'hDEAD_BEEF_CAFE_F00D;
        lsu_wmask     = 8'h0F;
        settle();
        check_vec("st_ready", 64'(lsu_req_ready), 64'd1);
        tick();
        // Scramble the requester side: the captured request must not move.
        lsu_req_valid = 1'b0;
        lsu_we        = 1'b0;
        lsu_addr      = 64'h1234;
        lsu_wdata     = 64'h0;
        lsu_wmask     = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready = 1'b1;
            settle();
            check_vec($sformatf("st_valid_%0d", i), 64'(mem_req_valid), 64'd1);
            check_vec($sformatf("st_addr_%0d", i),  mem_addr, 64'h0000_0000_8000_1000);
            check_vec($sformatf("st_wdata_%0d", i), mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
            check_vec($sformatf("st_wmask_%0d", i), 64'(mem_wmask), 64'h0F);
            check_vec($sformatf("st_we_%0d", i),    64'(mem_we), 64'd1);
            check_vec($sformatf("st_rsp_%0d", i),   64'({if_rsp_valid, lsu_rsp_valid}), 64'd0);
            tick();
        end
        mem_req_ready = 1'b0;
        settle();
        check_vec("st_rsp_wait_valid", 64'(mem_req_valid), 64'd0);
        check_vec("st_rsp_wait_lsu",   64'(lsu_rsp_valid), 64'd0);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0BAD_F00D_0000_0001;
        settle();
        check_vec("st_ack",      64'(lsu_rsp_valid), 64'd1);
        check_vec("st_ack_data", lsu_rsp_data, 64'h0BAD_F00D_0000_0001);
        check_vec("st_if_quiet", 64'(if_rsp_valid), 64'd0);
        tick();
        // mem_rsp_valid still high, now outside RSP: must be ignored.
        settle();
        check_vec("st_ack_once",  64'(lsu_rsp_valid), 64'd0);
        check_vec("st_if_quiet2", 64'(if_rsp_valid), 64'd0);
        check_vec("st_idle",      64'(dbg_state), 64'd0);
        tick();
        mem_rsp_valid = 1'b0;

        // ---------------- reset in the middle of REQ ----------------
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b0;
        lsu_addr      = 64'h0000_0000_8000_2008;
        settle();
        check_vec("mr_ready", 64'(lsu_req_ready), 64'd1);
        tick();
        lsu_req_valid = 1'b0;
        settle();
        check_vec("mr_in_req", 64'(mem_req_valid), 64'd1);
        rst = 1'b0;
        #1;
        check_vec("mr_valid_clr", 64'(mem_req_valid), 64'd0);
        check_vec("mr_busy_clr",  64'(busy), 64'd0);
        check_vec("mr_addr_clr",  mem_addr, 64'd0);
        check_vec("mr_state",     64'(dbg_state), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h5555_AAAA_5555_AAAA;
        settle();
        check_vec("mr_no_rsp", 64'({if_rsp_valid, lsu_rsp_valid}), 64'd0);
        check_vec("mr_idle",   64'(dbg_state), 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;

        // ---------------- starvation: both valids held high ----------------
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        if_req_valid  = 1'b1;
        if_addr       = 64'h0000_0000_8000_0000;
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b0;
        lsu_addr      = 64'h0000_0000_8000_3000;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0;
        grants  = 0;
        stall   = 0;
        exp_cnt = 4'd0;
        if_prev = 1'b0;
        for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
            settle();
            if (if_prev) check_vec("starve_clr", 64'(dbg_starve_cnt), 64'd0);
            if_prev = 1'b0;
            if (if_req_valid && !if_req_ready) stall++;
            if (if_req_ready || lsu_req_ready) begin
                check_vec("one_ready", 64'(if_req_ready & lsu_req_ready), 64'd0);
                exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
                check_vec($sformatf("grant_%0d", grants), 64'(lsu_req_ready), 64'(exp_g));
                check_vec($sformatf("starve_cnt_%0d", grants), 64'(dbg_starve_cnt), 64'(exp_cnt));
                if (lsu_req_ready) begin
                    exp_cnt = (exp_cnt == 4'd4) ? 4'd4 : exp_cnt + 4'd1;
                end else begin
                    exp_cnt = 4'd0;
                    if_prev = 1'b1;
                end
                grants++;
            end
            if (grants < 10) tick();
        end
        check_vec("starve_grants", 64'(grants), 64'd10);
        tick();
        if_req_valid  = 1'b0;
        lsu_req_valid = 1'b0;
        settle();
        if (if_prev) check_vec("starve_clr_last", 64'(dbg_starve_cnt), 64'd0);
        check_vec("starve_stall_cycles", 64'(stall), 64'd26);
`ifdef ARB_PERF_EN
        check_vec("perf_lsu_grants", 64'(perf_lsu_grants), 64'd8);
        check_vec("perf_if_grants",  64'(perf_if_grants), 64'd2);
        check_vec("perf_if_stall",   64'(perf_if_stall), 64'(stall));
`endif
        repeat (3) tick();
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        settle();
        check_vec("end_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory access port between two requesters: instruction fetch (IF, read-only) and load/store unit (LSU, read/write).
- Sits between the PC/fetch stage plus the MEM stage and the memory wrapper.
- Serialises requests with one outstanding transaction at a time.
- Uses fixed LSU-over-IF priority with a starvation guard for IF.
- Routes each memory response back to the requester that issued it.

Parameters:
- STARVE_MAX, 4: number of consecutive lost arbitrations after which a waiting IF request wins over LSU. Legal range 1..15; the counter is 4 bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
if_req_valid  input  1  IF fetch request
if_req_ready  output  1  IF request accepted this cycle
if_addr  input  64  fetch address, 4-byte aligned
if_rsp_valid  output  1  fetch data valid, one cycle
if_rsp_data  output  32  fetched instruction
lsu_req_valid  input  1  LSU request
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_we  input  1  1 = store, 0 = load
lsu_addr  input  64  data address
lsu_wdata  input  64  store data
lsu_wmask  input  8  store byte mask
lsu_rsp_valid  output  1  load data / store ack, one cycle
lsu_rsp_data  output  64  load data
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_we  output  1  write enable
mem_addr  output  64  address
mem_wdata  output  64  write data
mem_wmask  output  8  byte mask
mem_rsp_valid  input  1  memory response
mem_rsp_data  input  64  memory read data
busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low (rst=0 resets immediately).
- Reset values:
  - State = IDLE, owner = IF, starve_cnt = 0.
  - All valid/ready outputs and busy = 0.
  - mem_addr, mem_wdata, mem_wmask, mem_we = 0.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - Arbitrate only in this state; at most one ready asserted per cycle, combinationally from the valids.
  - Only LSU valid -> LSU wins.
  - Only IF valid -> IF wins.
  - Both valid -> LSU wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - On accept (valid & ready): register addr/we/wdata/wmask (IF: we=0, wmask=0, wdata=0), record owner, go to REQ.
- REQ:
  - mem_req_valid = 1, driven from the captured registers and held stable until mem_req_ready.
  - mem_req_valid & mem_req_ready -> RSP.
- RSP:
  - mem_req_valid = 0.
  - On mem_rsp_valid, pulse the owner's rsp_valid combinationally in the same cycle, then go to IDLE.
- Response data:
  - if_rsp_data = captured addr[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0].
  - lsu_rsp_data = mem_rsp_data, passed through.
  - A store also receives lsu_rsp_valid as its ack.
- mem_rsp_valid outside RSP is ignored.
- Latency:
  - Accept at cycle N.
  - mem_req_valid from N+1.
  - Earliest rsp_valid at N+2, when mem_req_ready is high at N+1 and mem_rsp_valid is high at N+2.
  - Minimum spacing between accepts is 3 cycles.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each LSU accept while if_req_valid = 1.
  - Clears on an IF accept.
  - Otherwise holds.
- Requester handshake rule: requesters hold valid and payload stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- Reset mid-transaction: state is forced to IDLE and outputs go to their reset values. Any response arriving after reset is ignored, and the requester must reissue.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined: adds outputs perf_if_grants (32), perf_lsu_grants (32) and perf_if_stall (32).
  - perf_if_grants / perf_lsu_grants: count accepts per requester.
  - perf_if_stall: counts cycles with if_req_valid=1 and if_req_ready=0.
  - All three are free-running, wrap at 2^32, and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 with both valids high -> all readies, mem_req_valid, rsp_valids and busy = 0. Release rst -> LSU ready first.
- IF fetch: if_addr=0x80000004, memory returns 0x11223344_55667788 with 0-wait ready and 1-cycle rsp -> if_rsp_valid at accept+2 with data 0x11223344; mem_we=0.
- LSU store with wait states: we=1, addr=0x80001000, wdata=0xDEADBEEF_CAFEF00D, wmask=0x0F, mem_req_ready delayed 3 cycles.
  - Required: mem_* stable throughout.
  - Required: lsu_rsp_valid pulses exactly once after mem_rsp_valid.
  - Required: if_rsp_valid stays 0.
- Starvation, STARVE_MAX=4: both valids held high continuously -> grant order LSU,LSU,LSU,LSU,IF,LSU,... and starve_cnt returns to 0 after the IF grant.
- Reset mid-REQ: assert rst=0 while mem_req_valid=1, release, then pulse mem_rsp_valid -> no rsp_valid on either side; FSM in IDLE.
- ARB_PERF_EN: run the starvation sequence for 10 grants -> perf_lsu_grants=8, perf_if_grants=2, and perf_if_stall equals the counted cycles with IF waiting.
